// File: rtl/cpu_bus_pkg.sv
// Shared CPU result-bus definitions: bus geometry, result source indices
// and the occupancy state of the registered result bus.
package cpu_bus_pkg;

  localparam int RESULT_W     = 64;
  localparam int N_RESULT_SRC = 4;

  // Requester index of each result producer on the bus.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MUL  = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_LINK = 2'd3
  } result_src_e;

  // Occupancy of the output register.
  typedef enum logic {
    BUS_EMPTY = 1'b0,
    BUS_FULL  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from
// ptr with wrap-around, done as a priority encode over {req, req & mask}.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0]   mask_s;
  logic [2*N_REQ-1:0] dbl_s;
  logic               found_s;

  // Keep only requesters at or above ptr in the low half; the high half
  // holds the unmasked requests so the search wraps to index 0.
  always_comb begin
    mask_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      mask_s[i] = (i >= int'(ptr)) ? 1'b1 : 1'b0;
    end
    dbl_s = {req, req & mask_s};
  end

  // Lowest set bit of the doubled vector; index truncation folds it mod N_REQ.
  always_comb begin
    win_idx = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < 2*N_REQ; i++) begin
      if (!found_s && dbl_s[i]) begin
        found_s = 1'b1;
        win_idx = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot form of the winner, zero when nobody requests.
  always_comb begin
    any    = |req;
    win_oh = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = any && (win_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing one registered result bus between N_REQ
// producers. Sustains one transfer per cycle while the consumer is ready.
module result_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ = N_RESULT_SRC,
  parameter int WIDTH = RESULT_W,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  bus_state_e       state_r, state_s;
  logic [SEL_W-1:0] ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic             load_s;
  logic             any_s;
  logic [N_REQ-1:0] win_oh_s;
  logic [SEL_W-1:0] win_idx_s;
  logic [WIDTH-1:0] win_data_s;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .any     (any_s),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s)
  );

  assign win_data_s = req_data[int'(win_idx_s)*WIDTH +: WIDTH];

  // Next-state and load decision; the register drains and refills on the
  // same edge, and a stalled FULL register blocks every grant.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      BUS_EMPTY: begin
        if (any_s) begin
          load_s  = 1'b1;
          state_s = BUS_FULL;
        end else begin
          state_s = BUS_EMPTY;
        end
      end
      BUS_FULL: begin
        if (out_ready) begin
          if (any_s) begin
            load_s  = 1'b1;
            state_s = BUS_FULL;
          end else begin
            state_s = BUS_EMPTY;
          end
        end else begin
          state_s = BUS_FULL;
        end
      end
      default: begin
        state_s = BUS_EMPTY;
      end
    endcase
  end

  // Acceptance pulse to the winning requester, suppressed during reset.
  always_comb begin
    if (load_s && !reset) begin
      gnt = win_oh_s;
    end else begin
      gnt = {N_REQ{1'b0}};
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= BUS_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Output word, its source index and the rotating priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r <= {WIDTH{1'b0}};
      out_sel_r  <= {SEL_W{1'b0}};
      ptr_r      <= {SEL_W{1'b0}};
    end else if (load_s) begin
      out_data_r <= win_data_s;
      out_sel_r  <= win_idx_s;
      ptr_r      <= win_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      out_data_r <= out_data_r;
      out_sel_r  <= out_sel_r;
      ptr_r      <= ptr_r;
    end
  end

  assign out_valid = (state_r == BUS_FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter with a queue-based scoreboard:
// stimulus pushes the hand-computed expected word, a monitor pops on accept.
module tb_result_bus_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   gnt;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [63:0]  dw [4];
  logic [63:0]  exp_data [$];
  logic [1:0]   exp_sel  [$];
  int           n_chk;
  int           n_fail;

  result_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  assign req_data = {dw[3], dw[2], dw[1], dw[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wa(input int i);
    return 64'hFEDC_BA98_7654_32A0 + 64'(i);
  endfunction

  function automatic logic [63:0] wb(input int k);
    return 64'h0123_4567_89AB_00B0 + 64'(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check gnt mid-cycle, record expected word.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] eg,
                     input bit push, input logic [63:0] ed, input logic [1:0] es,
                     input string nm);
    req = r;
    out_ready = rdy;
    @(negedge clk);
    chk({nm, " gnt"}, 64'(gnt), 64'(eg));
    if (push) begin
      exp_data.push_back(ed);
      exp_sel.push_back(es);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the next expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected word: got %h sel %0d expected none", out_data, out_sel);
      end else begin
        chk("out_data", out_data, exp_data.pop_front());
        chk("out_sel", 64'(out_sel), 64'(exp_sel.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) dw[i] = wa(i);
    reset = 1'b1;
    req = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_sel", 64'(out_sel), 64'd0);
    chk("reset out_data", out_data, 64'd0);

    // Load a word, then reset with everything requesting: word discarded.
    cyc(4'b0010, 1'b0, 4'b0010, 1'b0, 64'd0, 2'd0, "pre-reset load");
    chk("loaded out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    cyc(4'b1111, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0, "in reset");
    reset = 1'b0;
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset out_sel", 64'(out_sel), 64'd0);

    // All requesting: rotate 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b1, wa(k % 4), 2'(k % 4), "rotate");
      chk("rotate out_valid", 64'(out_valid), 64'd1);
    end

    // Only requester 2, back to back with changing data.
    for (int k = 0; k < 4; k++) begin
      dw[2] = wb(k);
      cyc(4'b0100, 1'b1, 4'b0100, 1'b1, wb(k), 2'd2, "solo2");
    end
    // ptr must be 3 now: requester 3 beats requester 1.
    cyc(4'b1010, 1'b1, 4'b1000, 1'b1, wa(3), 2'd3, "ptr after solo");
    dw[2] = wa(2);

    // Requester 1 loads, then a 3-cycle stall with req 0101.
    cyc(4'b0010, 1'b1, 4'b0010, 1'b1, wa(1), 2'd1, "load1");
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0101, 1'b0, 4'b0000, 1'b0, 64'd0, 2'd0, "stall");
      chk("stall out_data", out_data, wa(1));
      chk("stall out_sel", 64'(out_sel), 64'd1);
      chk("stall out_valid", 64'(out_valid), 64'd1);
    end
    cyc(4'b0101, 1'b1, 4'b0100, 1'b1, wa(2), 2'd2, "unstall");

    // Drain to empty, stale values retained, then a fresh request.
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0, "drain");
    chk("drained out_valid", 64'(out_valid), 64'd0);
    chk("stale out_sel", 64'(out_sel), 64'd2);
    chk("stale out_data", out_data, wa(2));
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0, "idle");
    chk("idle out_valid", 64'(out_valid), 64'd0);
    cyc(4'b0001, 1'b1, 4'b0001, 1'b1, wa(0), 2'd0, "wrap0");
    chk("latency out_valid", 64'(out_valid), 64'd1);
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 64'd0, 2'd0, "final drain");
    chk("final out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 20 && exp_data.size() != 0; i++) @(posedge clk);
    chk("scoreboard empty", 64'(exp_data.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Round-robin arbiter that shares one registered 64-bit result bus between `N_REQ` producers, such as the ALU, the multiplier, the load unit and the branch-link path, on their way to the register-file write port. It picks one requester per accepted transfer, drives the select for the shared data mux, holds the winning word in an output register until the consumer accepts it, and rotates priority so that no requester starves. With `out_ready` held high it sustains one transfer per cycle.

## Interface
- `N_REQ`, 4: number of requesters; must be a power of two, minimum 2.
- `WIDTH`, 64: data width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `N_REQ`  per-requester request; held high with stable data until the matching `gnt` bit is seen.
- `req_data`  in  `N_REQ*WIDTH`  flattened request data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `gnt`  out  `N_REQ`  one-hot or zero, combinational; bit i high means requester i's data is captured at this edge.
- `out_valid`  out  1  registered; the output register holds an unaccepted word.
- `out_data`  out  `WIDTH`  registered winning word.
- `out_sel`  out  `$clog2(N_REQ)`  registered index of the requester whose word is in `out_data`.
- `out_ready`  in  1  consumer accepts `out_data` when high together with `out_valid`.

## Operation
- States:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `load` = (state == EMPTY || `out_ready`) && |`req`.
- Winner: the first requester with `req` high, searching upward from `ptr` and wrapping at `N_REQ`-1 back to 0.
- `gnt` = one-hot(winner) when `load`, else 0.
- On `load`:
  - `out_data` <= winner's data; `out_sel` <= winner; next state FULL.
  - `ptr` <= (winner + 1) mod `N_REQ`, i.e. plain `$clog2` wrap-around.
- FULL with `out_ready` and no `req`: next state EMPTY. `out_data` and `out_sel` keep their stale values.
- FULL without `out_ready`: hold every register; `gnt` = 0 regardless of `req`.
- `ptr` moves only on `load`. It never moves on idle cycles or on stalls.
- Simultaneous accept and new request: one requester drains and a new one loads in the same edge, with no bubble cycle.
- A requester that raises `req` while FULL and stalled waits. Its priority is still evaluated against the current `ptr` when the stall clears.
- Reset behaviour:
  - `reset` wins over every other input.
  - Reset values: state EMPTY, `out_valid` 0, `out_data` 0, `out_sel` 0, `ptr` 0.
  - `gnt` is forced to 0 during the reset cycle.
  - A word held when reset arrives mid-transfer is discarded and is not delivered.

## Timing
- Latency from `req` rising (bus EMPTY, requester winning) to `out_valid` high: 1 cycle.
- Throughput with `out_ready` held high: 1 word per cycle.
- Requesters must treat `gnt` as an acceptance pulse.
  - Captured at the same edge as `out_data`.
  - A requester dropping `req` or presenting new data after seeing `gnt` is legal.
- `gnt` depends combinationally on `req`, `out_ready`, state and `ptr`.
  - `req` and `out_ready` must come from registers in the requesters and consumer, so no combinational loop forms.
- `out_valid`, `out_data` and `out_sel` are driven only from flops.

## Structure
- Shared package `cpu_bus_pkg`:
  - `RESULT_W` = 64.
  - `N_RESULT_SRC` = 4.
  - Requester-index enum: `SRC_ALU`, `SRC_MUL`, `SRC_LOAD`, `SRC_LINK`.
- Sub-module `rr_pick`:
  - Purely combinational; parameterised by `N_REQ`.
  - Inputs `req` and `ptr`; outputs `any`, a one-hot winner and a binary winner index.
  - Implemented as a double-width masked priority encode.
- Top level contains the state flop, `ptr`, the output register, and the `N_REQ`:1 data select indexed by the winner.

## Test plan
- Reset with `out_valid` high and `req`=4'b1111 → next cycle `out_valid`=0, `out_sel`=0, `gnt`=0; first `load` after reset grants requester 0.
- `req`=4'b1111 held, `out_ready`=1, data 64'hA0..A3 → `gnt` sequence 0001, 0010, 0100, 1000, 0001; `out_data` A0, A1, A2, A3 on consecutive cycles.
- Only requester 2 active, 4 transfers, `out_ready`=1 → 4 back-to-back grants to requester 2; `ptr` stays 3 after each load.
- FULL with requester 1's word, `out_ready`=0 for 3 cycles while `req`=4'b0101 → `out_data`/`out_sel` stable, `gnt`=0; when `out_ready` goes high, the same edge loads requester 2.
- One transfer, then `out_ready`=1 with `req`=0 → `out_valid` drops the next cycle; later `req`=4'b0001 → `out_valid` after 1 cycle.
- Random `req`/`out_ready` for 10k cycles with scoreboard:
  - Every `gnt` word appears exactly once at the output, in order.
  - No continuously requesting source waits more than `N_REQ` loads.
